// File: rtl/instr_exec_unit.sv
// Batch instruction executor: fetches words from an upstream register file,
// evaluates a signed ALU op per word and hands results out over valid/ready.
module instr_exec_unit #(
  parameter int PTR_W = 5,
  parameter int OP_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PTR_W-1:0]  start_ptr,
  input  logic [PTR_W:0]    num_instr,
  output logic [PTR_W-1:0]  read_pointer,
  input  logic [3:0]        iw_opcode,
  input  logic [OP_W-1:0]   iw_op_a,
  input  logic [OP_W-1:0]   iw_op_b,
  output logic [2*OP_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              err,
  output logic              busy,
  output logic              done
);

  localparam int RES_W = 2 * OP_W;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, OUT} state_t;

  state_t                   state, state_nx;
  logic [PTR_W-1:0]         ptr;
  logic [PTR_W:0]           remaining;
  logic [3:0]               op_q;
  logic [OP_W-1:0]          a_q, b_q;
  logic signed [RES_W-1:0]  a_ext, b_ext, alu_res;
  logic                     alu_err;
  logic                     launch, empty_start, handshake, last_instr;

  assign launch      = (state == IDLE) && start;
  assign empty_start = launch && (num_instr == '0);
  assign handshake   = (state == OUT) && result_ready;
  assign last_instr  = (remaining == (PTR_W+1)'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch && !empty_start) state_nx = FETCH;
      FETCH:   state_nx = EXEC;
      EXEC:    state_nx = OUT;
      OUT:     if (handshake) state_nx = last_instr ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    result_valid = (state == OUT);
    read_pointer = ptr;
  end

  // Widen before arithmetic so ADD/SUB/MULT/DIV cannot overflow (incl. MIN/-1).
  assign a_ext = {{OP_W{a_q[OP_W-1]}}, a_q};
  assign b_ext = {{OP_W{b_q[OP_W-1]}}, b_q};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op_q)
      4'd0: alu_res = '0;
      4'd1: alu_res = a_ext;
      4'd2: alu_res = b_ext;
      4'd3: alu_res = a_ext + b_ext;
      4'd4: alu_res = a_ext - b_ext;
      4'd5: alu_res = a_ext * b_ext;
      4'd6: if (b_q == '0) alu_err = 1'b1; else alu_res = a_ext / b_ext;
      4'd7: if (b_q == '0) alu_err = 1'b1; else alu_res = a_ext % b_ext;
      default: alu_err = 1'b1;
    endcase
  end

  // NOTE: every datapath register is reset so outputs read zero during reset
  // and a mid-batch reset leaves no stale operands behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      remaining <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result    <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (launch) begin
          ptr       <= start_ptr;
          remaining <= num_instr;
          done      <= empty_start;
        end
        FETCH: begin
          op_q <= iw_opcode;
          a_q  <= iw_op_a;
          b_q  <= iw_op_b;
        end
        EXEC: begin
          result <= alu_res;
          err    <= alu_err;
        end
        OUT: if (handshake) begin
          remaining <= remaining - (PTR_W+1)'(1);
          if (last_instr) done <= 1'b1;
          else            ptr  <= ptr + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Scoreboard bench for instr_exec_unit: stimulus pushes expected results from
// an arithmetic reference model; a negedge monitor compares what the DUT shows.
module tb_instr_exec_unit;

  localparam int RDY_RAND = 0;
  localparam int RDY_ONE  = 1;
  localparam int RDY_ZERO = 2;

  typedef struct {
    logic [63:0] res;
    logic        err;
    logic [4:0]  ptr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  start_ptr;
  logic [5:0]  num_instr;
  logic [4:0]  read_pointer;
  logic [3:0]  iw_opcode;
  logic [31:0] iw_op_a, iw_op_b;
  logic [63:0] result;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic        err, busy, done;

  logic [3:0]  mem_op[32];
  int          mem_a[32];
  int          mem_b[32];

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          rdy_mode = RDY_ONE;

  instr_exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .start_ptr(start_ptr),
    .num_instr(num_instr), .read_pointer(read_pointer), .iw_opcode(iw_opcode),
    .iw_op_a(iw_op_a), .iw_op_b(iw_op_b), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .err(err),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Upstream instruction register: combinational read at read_pointer.
  assign iw_opcode = mem_op[read_pointer];
  assign iw_op_a   = mem_a[read_pointer];
  assign iw_op_b   = mem_b[read_pointer];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  function automatic void ref_model(input logic [3:0] op, input int a, input int b,
                                    output logic [63:0] res, output logic e);
    longint r = 0;
    e = 1'b0;
    case (op)
      4'd0: r = 0;
      4'd1: r = longint'(a);
      4'd2: r = longint'(b);
      4'd3: r = longint'(a) + longint'(b);
      4'd4: r = longint'(a) - longint'(b);
      4'd5: r = longint'(a) * longint'(b);
      4'd6: if (b == 0) e = 1'b1; else r = longint'(a) / longint'(b);
      4'd7: if (b == 0) e = 1'b1; else r = longint'(a) % longint'(b);
      default: e = 1'b1;
    endcase
    res = r;
  endfunction

  function automatic int rand_operand();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return int'($urandom_range(0, 20)) - 10;
      2: return 32'h8000_0000;
      3: return -1;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      mem_op[i] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
      mem_a[i]  = rand_operand();
      mem_b[i]  = rand_operand();
    end
  endtask

  // Ready changes 2 time units after each rising edge, clear of both edges.
  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      RDY_RAND: result_ready = 1'($urandom_range(0, 1));
      RDY_ONE:  result_ready = 1'b1;
      default:  result_ready = 1'b0;
    endcase
  end

  // Monitor: every cycle a result is shown it must match the queue head;
  // the head is retired only when the handshake happens at the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        check("done_with_valid", 64'(result_valid), 64'd0);
      end
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(result_valid), 64'd0);
        end else begin
          check("result", result, exp_q[0].res);
          check("err", 64'(err), 64'(exp_q[0].err));
          check("read_pointer", 64'(read_pointer), 64'(exp_q[0].ptr));
          if (result_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rdy_mode = RDY_RAND;
  endtask

  // mode 0: plain, 1: start pulsed while busy, 2: first result held 5 cycles.
  task automatic run_batch(input int sp, input int n, input int mode);
    int base, cycles, k;
    base = done_cnt;
    for (int i = 0; i < n; i++) begin
      int   addr;
      exp_t x;
      addr = (sp + i) % 32;
      ref_model(mem_op[addr], mem_a[addr], mem_b[addr], x.res, x.err);
      x.ptr = 5'(addr);
      exp_q.push_back(x);
    end
    if (mode == 2 && n > 0) rdy_mode = RDY_ZERO;
    start_ptr = 5'(sp);
    num_instr = 6'(n);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_ptr = 5'($urandom);
    num_instr = 6'($urandom_range(0, 32));
    if (n == 0) begin
      check("empty_done", 64'(done), 64'd1);
      check("empty_busy", 64'(busy), 64'd0);
    end else begin
      check("busy_start", 64'(busy), 64'd1);
      cycles = 1;
      while (!result_valid && cycles < 20) begin
        @(posedge clk);
        #1 cycles++;
      end
      check("first_latency", 64'(cycles), 64'd3);
      if (mode == 1) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end else if (mode == 2) begin
        repeat (5) @(posedge clk);
        #1;
        check("hold_valid", 64'(result_valid), 64'd1);
        check("hold_ptr", 64'(read_pointer), 64'(sp % 32));
        rdy_mode = RDY_ONE;
        @(posedge clk);
        #1;
        check("valid_drop", 64'(result_valid), 64'd0);
        rdy_mode = RDY_RAND;
      end
    end
    k = 0;
    while (done_cnt == base && k < 2000) begin
      @(posedge clk);
      k++;
    end
    check("done_timeout", 64'(k < 2000), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - base), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
    if (k >= 2000) do_reset();
  endtask

  task automatic reset_mid_exec();
    int base;
    base      = done_cnt;
    start_ptr = 5'd7;
    num_instr = 6'd3;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    check("exec_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_read_pointer", 64'(read_pointer), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_done", 64'(done_cnt - base), 64'd0);
    check("rst_stays_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    start_ptr = '0;
    num_instr = '0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check("init_read_pointer", 64'(read_pointer), 64'd0);
    check("init_result", result, 64'd0);
    check("init_result_valid", 64'(result_valid), 64'd0);
    check("init_err", 64'(err), 64'd0);
    check("init_busy", 64'(busy), 64'd0);
    check("init_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ADD 5,3 / SUB 2,9 / MULT -4,6 -> 8, -7, -24
    mem_op[0] = 4'd3; mem_a[0] = 5;  mem_b[0] = 3;
    mem_op[1] = 4'd4; mem_a[1] = 2;  mem_b[1] = 9;
    mem_op[2] = 4'd5; mem_a[2] = -4; mem_b[2] = 6;
    rdy_mode = RDY_ONE;
    run_batch(0, 3, 0);

    // DIV by zero flags err; MOD keeps the sign of a
    mem_op[10] = 4'd6; mem_a[10] = 7;  mem_b[10] = 0;
    mem_op[11] = 4'd7; mem_a[11] = -7; mem_b[11] = 2;
    run_batch(10, 2, 0);

    // Overflow corners: MIN/-1, MIN*MIN, illegal opcode
    mem_op[12] = 4'd6; mem_a[12] = 32'h8000_0000; mem_b[12] = -1;
    mem_op[13] = 4'd5; mem_a[13] = 32'h8000_0000; mem_b[13] = 32'h8000_0000;
    mem_op[14] = 4'd11; mem_a[14] = 3; mem_b[14] = 4;
    rdy_mode = RDY_RAND;
    run_batch(12, 3, 0);

    run_batch(4, 2, 2);       // ready withheld for 5 cycles on first result
    run_batch(30, 4, 0);      // pointer wraps 30,31,0,1
    run_batch(20, 3, 1);      // start while busy is ignored
    run_batch(5, 0, 0);       // empty batch: done only
    reset_mid_exec();
    run_batch(7, 3, 0);       // fresh batch after abandoned one
    fill_random();
    run_batch(int'($urandom_range(0, 31)), 32, 0);

    for (int it = 0; it < 25; it++) begin
      int sp, n, mode;
      fill_random();
      sp   = int'($urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = 32;
        default: n = int'($urandom_range(1, 6));
      endcase
      mode = (n == 0) ? 0 : int'($urandom_range(0, 2));
      run_batch(sp, n, mode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
